// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one request at a time, waits a fixed
// latency, then returns a single-cycle response. busy feeds the CPU stall logic.
module mem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH_W = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << DEPTH_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic                wr_q;
  logic [DEPTH_W-1:0]  idx_q;
  logic [DATA_W-1:0]   wdata_q;

  // Storage is zero at time 0 only; reset never clears it.
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

  // Byte-address bit 0 and bits above the word index are intentionally dropped.
  logic                unused_addr;
  assign unused_addr = ^{req_addr[ADDR_W-1:DEPTH_W+1], req_addr[0]};

  // Commit selection: the edge that enters RESP performs the array access.
  logic                enter_resp;
  logic                cm_wr;
  logic [DEPTH_W-1:0]  cm_idx;
  logic [DATA_W-1:0]   cm_wdata;

  always_comb begin
    enter_resp = 1'b0;
    cm_wr      = wr_q;
    cm_idx     = idx_q;
    cm_wdata   = wdata_q;
    if (state == IDLE && req_valid && LATENCY == 1) begin
      enter_resp = 1'b1;
      cm_wr      = req_wr;
      cm_idx     = req_addr[DEPTH_W:1];
      cm_wdata   = req_wdata;
    end else if (state == WAIT && count == CNT_W'(1)) begin
      enter_resp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && cm_wr) mem[cm_idx] <= cm_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_wr;
            idx_q     <= req_addr[DEPTH_W:1];
            wdata_q   <= req_wdata;
            count     <= CNT_W'(LATENCY - 1);
            state     <= (LATENCY == 1) ? RESP : WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
      // A write echoes the new word; a read returns the stored one.
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_wr    <= cm_wr;
        rsp_rdata <= cm_wr ? cm_wdata : mem[cm_idx];
      end
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle data-memory responder. It is the slave end of the CPU/cache memory request interface.
- It accepts one read or write request at a time over a valid/ready handshake, holds it for a fixed LATENCY, and then returns a single-cycle response.
- It replaces the single-cycle memory model when the datapath moves to stalling memory accesses. Busy drives the CPU stall logic.

Parameters:
- ADDR_W, 16, request address width in bits (byte address).
- DATA_W, 16, data word width.
- DEPTH_W, 10, log2 of the storage depth in words (1024 words).
- LATENCY, 4, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address; bit 0 is ignored.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response pulse, one cycle.
- rsp_wr  output  1  type of the request being answered.
- rsp_rdata  output  DATA_W  read data, or echo of the written word.
- busy  output  1  a request is outstanding (state != IDLE).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state<=IDLE, counter<=0, rsp_valid<=0, rsp_wr<=0, rsp_rdata<=0.
  - busy=0 and req_ready=1 from the first cycle after reset.
  - Storage array is not cleared by reset; it initialises to all-zero at time 0 only.
- Word index = req_addr[DEPTH_W:1]. Address bits above DEPTH_W are ignored, so addresses alias modulo 2^(DEPTH_W+1) bytes.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance happens on an edge where req_valid=1. At that edge the block latches req_wr, word index and req_wdata, loads counter<=LATENCY-1 and moves to WAIT. If LATENCY=1 it goes directly to RESP.
  - With req_valid=0 it stays in IDLE.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when counter==1 the next state is RESP.
  - req_* inputs are ignored; requests presented while not ready have no effect and are not queued.
- RESP:
  - Occupies exactly one cycle; req_ready=0; next state is IDLE.
  - For a read, the latched word is read from the array.
  - For a write, the array word is updated at the edge entering RESP.
- Timing: a request accepted at the edge ending cycle k produces rsp_valid=1 in cycle k+LATENCY only.
  - rsp_wr equals the latched req_wr.
  - rsp_rdata equals the array word, which for a write is the newly written value.
  - rsp_rdata holds its value after the pulse until the next response.
- Throughput: one request per LATENCY+1 cycles; req_ready returns high in cycle k+LATENCY+1.
- Read-after-write to the same address issued back-to-back returns the new data, because the write commits before the read is accepted.
- Reset mid-operation: the outstanding request is dropped, no response is produced, and an uncommitted write is discarded (array unchanged).
- busy=1 in WAIT and RESP, and is equal to ~req_ready.
- No combinational path from any req_* input to any output.

Test Plan:
- Reset, then write req_addr=0x0010, req_wdata=0xBEEF at cycle 5 (LATENCY=4):
  - req_ready=0 in cycles 6-9.
  - In cycle 9: rsp_valid=1, rsp_wr=1, rsp_rdata=0xBEEF.
  - In cycle 10: req_ready=1.
- Read 0x0010 immediately after the write completes -> rsp_valid 4 cycles after acceptance with rsp_rdata=0xBEEF. Read 0x0011 -> also 0xBEEF (bit 0 ignored).
- Hold req_valid=1 with varying addresses during WAIT -> only the first accepted request is served, exactly one rsp_valid pulse, array unchanged by the ignored requests.
- Write 0x1234 to address 0x0004, then read 0x0804 (aliases with DEPTH_W=10) -> rsp_rdata=0x1234.
- Accept a write of 0xAAAA to 0x0020, then assert rst_n=0 two cycles later:
  - rsp_valid never pulses; all outputs return to their reset values.
  - A subsequent read of 0x0020 returns the prior contents (0x0000).
- LATENCY=1 build: accept a read at cycle k -> rsp_valid in cycle k+1, req_ready=1 again in cycle k+2. Back-to-back reads sustain one response every 2 cycles.
